// File: rtl/cv32e41p_pkg.sv
// Shared types for the cv32e41p instruction aligner.
package cv32e41p_pkg;

    typedef enum logic [1:0] {
        ALIGNED           = 2'd0,
        MISALIGNED32      = 2'd1,
        MISALIGNED16      = 2'd2,
        BRANCH_MISALIGNED = 2'd3
    } aligner_state_e;

endpackage

// File: rtl/cv32e41p_instr_aligner.sv
// Re-aligns 16/32-bit instructions from a word-aligned fetch stream, keeping
// the upper halfword of the last popped word for instructions that straddle words.
module cv32e41p_instr_aligner
    import cv32e41p_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        id_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_aligned_o,
    output logic        instr_compressed_o,
    output logic [31:0] pc_o
);

    aligner_state_e r_state;
    logic [31:0]    r_pc;
    logic [15:0]    r_half;

    aligner_state_e w_state_next;
    logic [31:0]    w_pc_next;
    logic [15:0]    w_half_next;
    logic           w_valid;
    logic           w_pop;
    logic [31:0]    w_instr;
    logic [31:0]    w_word;
    aligner_state_e w_upper_state;

    assign w_word = fetch_rdata_i;

    // Where we land after saving w[31:16]: a 32-bit head needs the next word.
    assign w_upper_state = (w_word[17:16] == 2'b11) ? MISALIGNED32 : MISALIGNED16;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_half_next  = r_half;
        w_valid      = 1'b0;
        w_pop        = 1'b0;
        w_instr      = w_word;

        case (r_state)
            ALIGNED: begin
                w_valid = fetch_valid_i;
                if (w_word[1:0] == 2'b11) begin
                    w_instr = w_word;
                    if (w_valid && id_ready_i) begin
                        w_pc_next = r_pc + 32'd4;
                        w_pop     = 1'b1;
                    end
                end else begin
                    w_instr = {16'h0000, w_word[15:0]};
                    if (w_valid && id_ready_i) begin
                        w_pc_next    = r_pc + 32'd2;
                        w_pop        = 1'b1;
                        w_half_next  = w_word[31:16];
                        w_state_next = w_upper_state;
                    end
                end
            end
            MISALIGNED32: begin
                w_valid = fetch_valid_i;
                w_instr = {w_word[15:0], r_half};
                if (w_valid && id_ready_i) begin
                    w_pc_next    = r_pc + 32'd4;
                    w_pop        = 1'b1;
                    w_half_next  = w_word[31:16];
                    w_state_next = w_upper_state;
                end
            end
            MISALIGNED16: begin
                // The saved halfword is a complete instruction; no fetch needed.
                w_valid = 1'b1;
                w_instr = {16'h0000, r_half};
                if (id_ready_i) begin
                    w_pc_next    = r_pc + 32'd2;
                    w_state_next = ALIGNED;
                end
            end
            BRANCH_MISALIGNED: begin
                w_instr = {16'h0000, w_word[31:16]};
                if (w_word[17:16] != 2'b11) begin
                    w_valid = fetch_valid_i;
                    if (w_valid && id_ready_i) begin
                        w_pc_next    = r_pc + 32'd2;
                        w_pop        = 1'b1;
                        w_state_next = ALIGNED;
                    end
                end else if (fetch_valid_i) begin
                    w_pop        = 1'b1;
                    w_half_next  = w_word[31:16];
                    w_state_next = MISALIGNED32;
                end
            end
            default: begin
                w_state_next = ALIGNED;
            end
        endcase

        if (branch_i) begin
            w_valid      = 1'b0;
            w_pop        = 1'b0;
            w_pc_next    = branch_addr_i;
            w_state_next = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ALIGNED;
            r_pc    <= 32'h0000_0000;
            r_half  <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_half  <= w_half_next;
        end
    end

    assign instr_valid_o      = w_valid;
    assign fetch_ready_o      = w_pop;
    assign instr_aligned_o    = w_instr;
    assign instr_compressed_o = (w_instr[1:0] != 2'b11);
    assign pc_o               = r_pc;

endmodule

// File: tb/tb_cv32e41p_instr_aligner.sv
// Bench for the instruction aligner: a halfword-addressed program memory feeds
// a word-aligned fetch stream, and availability rules predict every output.
module tb_cv32e41p_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        id_ready_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_aligned_o;
    logic        instr_compressed_o;
    logic [31:0] pc_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] mem [256];
    logic [31:0] m_pc;
    logic [31:0] m_fa;

    always #5 clk = ~clk;

    cv32e41p_instr_aligner dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_ready_o      (fetch_ready_o),
        .id_ready_i         (id_ready_i),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .instr_valid_o      (instr_valid_o),
        .instr_aligned_o    (instr_aligned_o),
        .instr_compressed_o (instr_compressed_o),
        .pc_o               (pc_o)
    );

    function automatic logic [15:0] hw(input logic [31:0] a);
        return mem[a[8:1]];
    endfunction

    // Halfword at offset off from the fetch word is held if it sits just
    // below the word (already popped), or present if inside the valid word.
    function automatic logic avail(input logic [31:0] off, input logic fv);
        if (off == 32'hFFFF_FFFE) return 1'b1;
        if (off == 32'd0 || off == 32'd2) return fv;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[8:1]]          = w[15:0];
        mem[a[8:1] + 8'd1]   = w[31:16];
    endtask

    task automatic step(input logic fv, input logic idr, input logic br, input logic [31:0] baddr);
        logic [15:0] h0;
        logic        len4;
        logic [31:0] exp_instr;
        logic [31:0] last;
        logic        exp_valid;
        logic        exp_pop;
        fetch_valid_i = fv;
        id_ready_i    = idr;
        branch_i      = br;
        branch_addr_i = baddr;
        fetch_rdata_i = {hw(m_fa + 32'd2), hw(m_fa)};
        #1;
        h0        = hw(m_pc);
        len4      = (h0[1:0] == 2'b11);
        exp_instr = len4 ? {hw(m_pc + 32'd2), h0} : {16'h0000, h0};
        last      = len4 ? m_pc + 32'd2 : m_pc;
        exp_valid = !br && avail(m_pc - m_fa, fv) && (!len4 || avail(m_pc + 32'd2 - m_fa, fv));
        exp_pop   = !br && fv &&
                    ((exp_valid && idr && ((last - m_fa) < 32'd4)) ||
                     (!exp_valid && (m_pc - m_fa) == 32'd2 && len4));
        chk("valid", {31'b0, instr_valid_o}, {31'b0, exp_valid});
        chk("pc", pc_o, m_pc);
        chk("pop", {31'b0, fetch_ready_o}, {31'b0, exp_pop});
        if (exp_valid) begin
            chk("instr", instr_aligned_o, exp_instr);
            chk("compressed", {31'b0, instr_compressed_o}, {31'b0, !len4});
        end
        if (exp_valid && idr)
            $display("accept pc=%h instr=%h pop=%0d", m_pc, exp_instr, exp_pop);
        else if (br)
            $display("branch to %h", baddr);
        @(posedge clk);
        if (br) begin
            m_pc = baddr;
            m_fa = {baddr[31:2], 2'b00};
        end else begin
            if (exp_valid && idr) m_pc = m_pc + (len4 ? 32'd4 : 32'd2);
            if (exp_pop) m_fa = m_fa + 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        put(32'h000, 32'h0000_0013);
        put(32'h004, 32'h0010_0093);
        put(32'h040, 32'h0093_4501);
        put(32'h044, 32'h0013_0000);
        put(32'h080, 32'h4505_4501);
        put(32'h100, 32'h0093_1234);
        put(32'h104, 32'h0013_0000);
        put(32'h140, 32'h0093_4501);
        put(32'h144, 32'h4509_0010);
        put(32'h180, 32'h4505_4501);
        m_pc = 32'h0;
        m_fa = 32'h0;

        // Reset: outputs follow ALIGNED, nothing advances.
        rst_n         = 1'b0;
        fetch_valid_i = 1'b1;
        id_ready_i    = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        fetch_rdata_i = 32'h0000_0013;
        @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("rst_pop", {31'b0, fetch_ready_o}, 32'd1);
        chk("rst_pc", pc_o, 32'h0);
        @(negedge clk);
        chk("rst_pc_hold", pc_o, 32'h0);
        rst_n = 1'b1;

        // Two aligned 32-bit instructions.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        // c.li then a straddling 32-bit instruction.
        step(0, 0, 1, 32'h040);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        // Two c.li in one word; the second needs no fetch.
        step(0, 0, 1, 32'h080);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        // Misaligned branch target with 32-bit head: bubble then output.
        step(0, 0, 1, 32'h102);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        // Stall in MISALIGNED32 for three cycles.
        step(0, 0, 1, 32'h140);
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        // Branch overrides a pending MISALIGNED16 output.
        step(0, 0, 1, 32'h180);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h000);
        // Reset asserted while in MISALIGNED32 drops the saved halfword.
        step(0, 0, 1, 32'h140);
        step(1, 1, 0, 0);
        fetch_valid_i = 1'b0;
        id_ready_i    = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("midrst_pc", pc_o, 32'h0);
        chk("midrst_valid", {31'b0, instr_valid_o}, 32'd0);
        m_pc = 32'h0;
        m_fa = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0);
        // Wrap of pc arithmetic past 0xFFFFFFFE.
        mem[8'hFE] = 16'h4501;
        mem[8'hFF] = 16'h4505;
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);

        // Random program and random handshake/branch traffic.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        step(0, 0, 1, 32'h0000_0000);
        for (int i = 0; i < 600; i++) begin
            logic        br;
            logic [31:0] ba;
            br = ($urandom_range(0, 19) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            ba[0] = 1'b0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, br, ba);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cv32e41p_instr_aligner.md
CV32E41P_INSTR_ALIGNER -- requirements
Module: cv32e41p_instr_aligner

Interface
REQ-001 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port fetch_valid_i  input  1  fetch word valid from prefetch buffer.
REQ-004 SHALL have port fetch_rdata_i  input  32  fetch word; the word-aligned address is implied by pc.
REQ-005 SHALL have port fetch_ready_o  output  1  fetch word consumed this cycle (pop).
REQ-006 SHALL have port id_ready_i  input  1  decode accepts the presented instruction.
REQ-007 SHALL have port branch_i  input  1  redirect fetch stream; prefetch buffer flushes in the same cycle.
REQ-008 SHALL have port branch_addr_i  input  32  redirect target; bit 0 is always 0.
REQ-009 SHALL have port instr_valid_o  output  1  instr_aligned_o/pc_o valid.
REQ-010 SHALL have port instr_aligned_o  output  32  aligned instruction; compressed instructions are zero-extended in bits 31:16.
REQ-011 SHALL have port instr_compressed_o  output  1  presented instruction is 16-bit (bits 1:0 != 2'b11).
REQ-012 SHALL have port pc_o  output  32  address of the presented instruction.
REQ-013 SHALL have no parameters.

Function
REQ-014 SHALL hold state, pc_q[31:0] and half_q[15:0], where half_q is the saved upper halfword of the last consumed word.
REQ-015 SHALL implement the states ALIGNED, MISALIGNED32, MISALIGNED16 and BRANCH_MISALIGNED.
REQ-016 SHALL define "accept" as instr_valid_o && id_ready_i; pc_q, state and half_q SHALL change only on accept, on branch_i, or in the BRANCH_MISALIGNED pop case.
REQ-017 ALIGNED: instr_valid_o=fetch_valid_i. Bits 1:0 == 11: output the word, compressed=0; on accept pc+=4, pop, stay ALIGNED.
REQ-018 ALIGNED, compressed: output {16'h0, w[15:0]}; on accept pc+=2, pop, half_q<=w[31:16]. Next state MISALIGNED32 if w[17:16]==11, else MISALIGNED16.
REQ-019 MISALIGNED32: instr_valid_o=fetch_valid_i; output {w[15:0], half_q}; on accept pc+=4, pop, half_q<=w[31:16]. Next state per w[17:16] as in REQ-018.
REQ-020 MISALIGNED16: instr_valid_o=1 independent of fetch_valid_i; output {16'h0, half_q}, compressed=1; fetch_ready_o=0. On accept pc+=2 and next state ALIGNED.
REQ-021 BRANCH_MISALIGNED, w[17:16]!=11: instr_valid_o=fetch_valid_i; output {16'h0, w[31:16]}; on accept pc+=2, pop, next state ALIGNED.
REQ-022 BRANCH_MISALIGNED, w[17:16]==11: instr_valid_o=0. When fetch_valid_i=1: pop, half_q<=w[31:16], next state MISALIGNED32, pc unchanged. This is the one-cycle bubble.
REQ-023 fetch_ready_o SHALL equal 1 only on a pop as defined above; it is never asserted when fetch_valid_i=0.
REQ-024 branch_i SHALL have priority over every other event and SHALL force instr_valid_o=0 and fetch_ready_o=0 that cycle.
REQ-025 On branch_i: pc_q<=branch_addr_i. Next state BRANCH_MISALIGNED if branch_addr_i[1] is 1, else ALIGNED. half_q is don't-care.
REQ-026 pc_o SHALL equal pc_q combinationally; pc arithmetic SHALL be 32-bit modulo (0xFFFFFFFE+2 wraps to 0).
REQ-027 Outputs SHALL be held stable while instr_valid_o=1 and id_ready_i=0, provided fetch_rdata_i is stable.
REQ-028 SHALL have zero-cycle latency: fetch word to instr_valid_o is combinational.

Reset
REQ-029 On rst_n=0: state=ALIGNED, pc_q=0, half_q=0, asynchronously.
REQ-030 During reset: instr_valid_o, fetch_ready_o and instr_compressed_o SHALL follow state ALIGNED with fetch_valid_i. No accept or pop SHALL take effect until rst_n is released.
REQ-031 Reset asserted mid-MISALIGNED32 SHALL discard half_q with no output.

Structure
REQ-032 The aligner state enum (4 states, 2 bits) SHALL live in cv32e41p_pkg; no other typedefs are needed.
REQ-033 SHALL be a single module with no sub-modules; compressed expansion stays in the existing decoder stage.

Verification
REQ-034 After reset, words 0x00000013 then 0x00100093: two 32-bit instructions at pc 0x0 and 0x4, two pops.
REQ-035 Word 0x00934501 (c.li at 0x0, 32-bit head 0x0093 at 0x2) then 0x00130000: outputs 0x00004501 at pc 0x0, then 0x00000093 at pc 0x2, with one pop per word.
REQ-036 Word 0x45054501 (two c.li): 0x4501 at pc 0x0 with a pop, then 0x4505 at pc 0x2 with fetch_ready_o=0 and fetch_valid_i=0.
REQ-037 branch_i with addr 0x102, first word 0x0093xxxx: one bubble cycle, then 0x00000093 at pc 0x102 taken from the next word's low half.
REQ-038 id_ready_i=0 for 3 cycles in MISALIGNED32: outputs, pc_o and state stable, no pop. branch_i arriving in MISALIGNED16 overrides the pending output and instr_valid_o=0.
